// File: rtl/watch_pkg.sv
// Watch datapath shared types and constants.
// Field limits, widths and the modular step helper.
package watch_pkg;

    localparam int CS_W   = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [CS_W-1:0]   CS_MAX   = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef struct packed {
        logic [CS_W-1:0]   cs;
        logic [SEC_W-1:0]  sec;
        logic [MIN_W-1:0]  min;
        logic [HOUR_W-1:0] hour;
    } time_t;

    // (cur + cin + up - dn) mod (top + 1); covers -1 .. top+2
    function automatic logic [6:0] mod_step(
        input logic [6:0] cur,
        input logic [6:0] top,
        input logic       cin,
        input logic       up,
        input logic       dn
    );
        int v;
        int n;
        n = int'(top) + 1;
        v = int'(cur) + int'(cin) + int'(up) - int'(dn);
        if (v < 0)
            v = v + n;
        else if (v >= n)
            v = v - n;
        return 7'(v);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Centisecond prescaler with synchronous clear.
// tick is registered and high in the cycle before the counter wraps.
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

    logic [CW-1:0] cnt;

    // count 0..DIV-1; flag the last count so tick lines up with the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
            tick <= (cnt == PRE);
        end
    end

endmodule

// File: rtl/watch_dp.sv
// Watch time-keeping datapath: cs/sec/min/hour cascade
// with single-cycle up/down adjust of the selected field.
module watch_dp
    import watch_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int INIT_HOUR = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel_sec,
    input  logic       sel_min,
    input  logic       sel_hour,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [6:0] cs,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       tick
);

    time_t tm_q;
    time_t tm_d;

    logic adj_ok;
    logic adj_up;
    logic adj_dn;
    logic clr;
    logic cs_wrap;
    logic sec_wrap;
    logic min_cin;
    logic hour_cin;

    assign adj_ok = $onehot({sel_hour, sel_min, sel_sec})
                    && (btn_up ^ btn_down);
    assign adj_up = adj_ok && btn_up;
    assign adj_dn = adj_ok && btn_down;
    assign clr    = adj_ok && sel_sec;

    // a seconds adjust swallows any same-cycle tick and its carries
    assign cs_wrap  = tick && !clr && (tm_q.cs == CS_MAX);
    assign sec_wrap = cs_wrap && (tm_q.sec == SEC_MAX);
    assign min_cin  = sec_wrap;
    assign hour_cin = min_cin && !(adj_ok && sel_min)
                      && (tm_q.min == MIN_MAX);

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    // next time: clear/tick on cs+sec, carry plus adjust on min/hour
    always_comb begin
        tm_d = tm_q;
        if (clr) begin
            tm_d.cs  = '0;
            tm_d.sec = '0;
        end else if (tick) begin
            tm_d.cs = cs_wrap ? '0 : tm_q.cs + 7'd1;
            if (cs_wrap)
                tm_d.sec = sec_wrap ? '0 : tm_q.sec + 6'd1;
        end
        tm_d.min = MIN_W'(mod_step(7'(tm_q.min), 7'(MIN_MAX),
                                   min_cin,
                                   adj_up && sel_min,
                                   adj_dn && sel_min));
        tm_d.hour = HOUR_W'(mod_step(7'(tm_q.hour), 7'(HOUR_MAX),
                                     hour_cin,
                                     adj_up && sel_hour,
                                     adj_dn && sel_hour));
    end

    // time registers; hour comes out of reset at INIT_HOUR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tm_q.cs   <= '0;
            tm_q.sec  <= '0;
            tm_q.min  <= '0;
            tm_q.hour <= HOUR_W'(INIT_HOUR);
        end else begin
            tm_q <= tm_d;
        end
    end

    assign cs   = tm_q.cs;
    assign sec  = tm_q.sec;
    assign min  = tm_q.min;
    assign hour = tm_q.hour;

endmodule
